// File: rtl/croc_io_cond_if.sv
// croc_io_cond_if
// Groups the pad-side inputs and conditioned SoC-side outputs of the
// croc_io_cond input conditioning stage. Clock and pad reset stay plain
// ports on the module.
//
//   testmode_i  : quasi-static test mode select (bypasses reset stretch)
//   fetch_en_i  : raw asynchronous pad fetch enable
//   uart_rx_i   : raw asynchronous pad UART RX (idle 1)
//   rst_no      : active-low reset to the SoC
//   fetch_en_o  : synchronized, debounced fetch enable
//   uart_rx_o   : synchronized, glitch-filtered UART RX
//
// master: the pad ring / environment side, drives the raw inputs.
// slave : the conditioning block, drives the conditioned outputs.
interface croc_io_cond_if;
   logic testmode_i;
   logic fetch_en_i;
   logic uart_rx_i;
   logic rst_no;
   logic fetch_en_o;
   logic uart_rx_o;

   modport master (
      output testmode_i,
      output fetch_en_i,
      output uart_rx_i,
      input  rst_no,
      input  fetch_en_o,
      input  uart_rx_o
   );

   modport slave (
      input  testmode_i,
      input  fetch_en_i,
      input  uart_rx_i,
      output rst_no,
      output fetch_en_o,
      output uart_rx_o
   );
endinterface

// File: rtl/croc_io_cond.sv
// croc_io_cond
// Input conditioning between the pad ring and croc_soc:
//   - reset asserts asynchronously, releases synchronously after a hold stretch
//   - fetch enable is synchronized and debounced (only while the SoC runs)
//   - UART RX is synchronized and 3-tap majority filtered
//
// Ports:
//   clk_i  : SoC clock, all flops rising-edge
//   rst_ni : pad reset, asynchronous active-low, resets every flop here
//   io     : croc_io_cond_if.slave (testmode/fetch/uart in, rst/fetch/uart out)
module croc_io_cond #(
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned RstHoldCycles  = 16,
   parameter int unsigned DebounceCycles = 1024
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   croc_io_cond_if.slave  io
);

   localparam int unsigned HoldW = $clog2(RstHoldCycles + 1);
   localparam int unsigned DebW  = $clog2(DebounceCycles + 1);

   typedef enum logic [1:0] {
      RESET,
      HOLD,
      RUN
   } state_e;

   state_e              state_q, state_d;
   logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
   logic                rst_flag_q;
   logic [SyncStages-1:0] rst_sync_q;
   logic                rsync;

   logic [SyncStages-1:0] fetch_sync_q;
   logic                fsync;
   logic [DebW-1:0]     deb_cnt_q;
   logic                fetch_q;

   logic [SyncStages-1:0] uart_sync_q;
   logic [2:0]          hist_q;
   logic                uart_q;

   // Reset release synchronizer: clears asynchronously, fills with ones
   // once the pad reset is released.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[SyncStages-2:0], 1'b1};
      end
   end

   assign rsync = rst_sync_q[SyncStages-1];

   // Reset FSM state, hold counter and the registered release flag.
   // The flag tracks the next state so it is high exactly while in RUN.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RESET;
         hold_cnt_q <= '0;
         rst_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         rst_flag_q <= (state_d == RUN);
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         RESET: begin
            if (rsync) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         HOLD: begin
            if (hold_cnt_q == HoldW'(RstHoldCycles - 1)) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Test mode hands the pad reset straight through in both directions.
   assign io.rst_no = io.testmode_i ? rst_ni : rst_flag_q;

   // Fetch enable synchronizer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_sync_q <= '0;
      end else begin
         fetch_sync_q <= {fetch_sync_q[SyncStages-2:0], io.fetch_en_i};
      end
   end

   assign fsync = fetch_sync_q[SyncStages-1];

   // Debounce: the output only follows the synchronized input after it has
   // differed for DebounceCycles consecutive cycles; any reversion restarts
   // the count. Held at zero until the SoC is out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         deb_cnt_q <= '0;
         fetch_q   <= 1'b0;
      end else if (state_q != RUN) begin
         deb_cnt_q <= '0;
         fetch_q   <= 1'b0;
      end else if (fsync == fetch_q) begin
         deb_cnt_q <= '0;
      end else if (deb_cnt_q == DebW'(DebounceCycles - 1)) begin
         deb_cnt_q <= '0;
         fetch_q   <= ~fetch_q;
      end else begin
         deb_cnt_q <= deb_cnt_q + DebW'(1);
      end
   end

   assign io.fetch_en_o = fetch_q;

   // UART synchronizer and 3-deep history, both idling high.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         uart_sync_q <= '1;
         hist_q      <= 3'b111;
      end else begin
         uart_sync_q <= {uart_sync_q[SyncStages-2:0], io.uart_rx_i};
         hist_q      <= {hist_q[1:0], uart_sync_q[SyncStages-1]};
      end
   end

   // Majority vote over the history removes single-cycle glitches.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         uart_q <= 1'b1;
      end else begin
         uart_q <= (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                   (hist_q[1] & hist_q[2]);
      end
   end

   assign io.uart_rx_o = uart_q;

endmodule

// File: doc/croc_io_cond.md
# croc_io_cond

Input conditioning stage between the chip pad ring and `croc_soc`. It turns the raw asynchronous pad signals `rst_ni`, `fetch_en_i` and `uart_rx_i` into clean, clock-synchronous signals for the SoC:
- a reset that asserts asynchronously and releases synchronously after a stretch;
- a synchronized, debounced fetch enable;
- a synchronized, glitch-filtered UART receive line.

Test mode bypasses the reset stretch.

## Interface
- `SyncStages`, 2: flops per synchronizer chain; at least 2.
- `RstHoldCycles`, 16: cycles the SoC reset is held after the synchronized release; at least 1.
- `DebounceCycles`, 1024: consecutive stable cycles required before `fetch_en_o` changes; at least 1.

- `clk_i`  in  1  SoC clock; all flops are rising-edge.
- `rst_ni`  in  1  pad reset; asynchronous, active-low. Resets every flop in this block.
- `testmode_i`  in  1  quasi-static. When 1, `rst_no` is `rst_ni` directly.
- `fetch_en_i`  in  1  raw pad fetch enable; asynchronous.
- `uart_rx_i`  in  1  raw pad UART RX; asynchronous; idle level 1.
- `rst_no`  out  1  reset to `croc_soc`; active-low.
- `fetch_en_o`  out  1  conditioned fetch enable.
- `uart_rx_o`  out  1  conditioned UART RX.

## Operation
**Reset FSM.** States are RESET, HOLD and RUN. The state register is reset to RESET.
- A chain of `SyncStages` flops resets to 0 and shifts in constant 1. Call its output `rsync`.
- RESET: go to HOLD when `rsync`=1, with the counter cleared to 0.
- HOLD: counter increments each cycle. At counter = `RstHoldCycles`-1, go to RUN.
- RUN: terminal state until `rst_ni` is asserted.
- `rst_no` is a registered flag, 1 only in RUN, reset to 0.
- Output mux: `rst_no` = `testmode_i` ? `rst_ni` : flag.
- Counter width is $clog2(`RstHoldCycles`+1).

**Fetch enable.**
- Synchronized by a `SyncStages` chain reset to 0, giving `fsync`.
- Debounce counter width is $clog2(`DebounceCycles`+1).
- When `fsync` equals `fetch_en_o`, the counter clears.
- When they differ and counter = `DebounceCycles`-1, `fetch_en_o` toggles and the counter clears.
- When they differ otherwise, the counter increments.
- While the state is not RUN, the counter and `fetch_en_o` are held at 0.

**UART RX.**
- Synchronized by a `SyncStages` chain reset to 1.
- The synchronized value feeds a 3-bit history `h[2:0]`, reset to 3'b111.
- `uart_rx_o` is the registered majority of `h`, reset to 1.
- A 1-cycle glitch in the synchronized stream never reaches `uart_rx_o`.
- The UART path is not gated by the FSM state.

## Timing
Edges are counted from the first rising edge at which `rst_ni` is sampled high.

- **Reset values.** During `rst_ni`=0:
  - `rst_no`=0 immediately, with no clock needed.
  - `fetch_en_o`=0.
  - `uart_rx_o`=1.
- **Reset release.** `rst_no` rises after edge `SyncStages`+`RstHoldCycles`+1: 19 edges with the defaults.
- **Reset mid-operation.** Any `rst_ni` low pulse, even shorter than a clock period, forces `rst_no`=0 asynchronously and returns the FSM to RESET. The full release sequence then repeats.
- **Test mode.** With `testmode_i`=1, `rst_no` follows `rst_ni` combinationally in both directions. The FSM still runs internally.
- **Fetch enable latency.** A pad change held stable reaches `fetch_en_o` exactly `SyncStages`+`DebounceCycles` edges after the sampling edge.
  - This applies only in RUN.
  - A pad that already differs when RUN is entered needs `DebounceCycles` edges after entry.
  - A reversion shorter than `DebounceCycles` cycles clears the counter; the output does not move.
- **UART latency.** A sustained pad change reaches `uart_rx_o` `SyncStages`+3 edges after the sampling edge.
- **Simultaneous events.** Reset assertion overrides debounce and filter activity in the same cycle.

## Test plan
- **Reset release.** Hold `rst_ni`=0 for 5 cycles, then release. Check `rst_no`=0 through edge 18 and `rst_no`=1 after edge 19. `fetch_en_o`=0 and `uart_rx_o`=1 throughout.
- **Mid-stretch reset.** Release `rst_ni`, pulse it low for 3 ns at edge 10, release again. Check `rst_no` never rises during the first attempt, then rises 19 edges after the second release.
- **Debounce.** Run with `DebounceCycles`=8 in RUN.
  - Hold `fetch_en_i`=1 for 20 cycles: `fetch_en_o` rises exactly 10 edges after the sampling edge.
  - Apply a 7-cycle pulse: `fetch_en_o` stays 0.
- **UART filter.** In any state, send a 1-cycle low glitch on `uart_rx_i`: `uart_rx_o` stays 1. Hold the line low for 6 cycles: `uart_rx_o` falls 5 edges after the sampling edge, then returns to 1 5 edges after the line goes high again.
- **Test mode.** With `testmode_i`=1, toggle `rst_ni` asynchronously: `rst_no` tracks it with zero clock delay. Set `testmode_i`=0 after 19+ clean cycles: `rst_no`=1.
- **Fetch during reset.** Hold `fetch_en_i`=1 from time 0, then release reset. With `DebounceCycles`=8, `fetch_en_o` rises 8 edges after `rst_no` rises, never before.
